adc2v_mc: RTL

//  Multi-channel successor to the single-channel ADC-to-voltage stage.
//  - Accepts a time-multiplexed stream of channel-tagged raw ADC samples.
//  - Converts each sample to a signed fixed-point voltage using a per-channel bias and a per-channel gain.
//  - Each channel's bias and gain are writable at runtime.
//  - Sits between the ADC front end and the cnn1d input buffers; the output stream keeps its channel tag.

---
 rtl/cnn1d_pkg.sv | 20 ++
 rtl/adc2v_mc_coef_bank.sv | 49 ++++
 rtl/mult.sv | 41 ++++
 rtl/adc2v_mc.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cnn1d_pkg.sv
// Shared types for the cnn1d front end: ADC code width, per-channel
// coefficient record and the coefficient-select encoding.
package cnn1d_pkg;

    localparam int ADC_WIDTH = 12;

    // Coefficient storage width; the adc2v_mc datapath width must match.
    localparam int COEF_W = 32;

    typedef struct packed {
        logic [COEF_W-1:0] bias;   // signed integer mV
        logic [COEF_W-1:0] gain;   // signed fixed point, FRACTION fractional bits
    } coef_t;

    typedef enum logic {
        CFG_BIAS = 1'b0,
        CFG_GAIN = 1'b1
    } cfg_sel_e;

endpackage

// File: rtl/adc2v_mc_coef_bank.sv
// Per-channel bias/gain registers: async reset to the init values, one
// write port (out-of-range channel ignored), combinational read by tag.
module adc2v_coef_bank
    import cnn1d_pkg::*;
#(
    parameter int               NUM_CH    = 4,
    parameter int               CH_W      = 2,
    parameter logic [COEF_W-1:0] BIAS_INIT = 32'hfffffb1e,
    parameter logic [COEF_W-1:0] GAIN_INIT = 32'h000aaaab
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  cfg_sel_e          sel,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [COEF_W-1:0] wr_data,
    input  logic [CH_W-1:0]   rd_ch,
    output coef_t             rd_coef
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    coef_t bank [NUM_CH];
    logic  wr_ok;
    logic  rd_ok;

    assign wr_ok = ({1'b0, wr_ch} < NUM_CH_L);
    assign rd_ok = ({1'b0, rd_ch} < NUM_CH_L);

    // Coefficient registers; only the selected field of one channel changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank[i].bias <= BIAS_INIT;
                bank[i].gain <= GAIN_INIT;
            end
        end else if (we && wr_ok) begin
            if (sel == CFG_GAIN) bank[wr_ch].gain <= wr_data;
            else                 bank[wr_ch].bias <= wr_data;
        end
    end

    // Read returns zeros for tags outside the bank; such samples are dropped anyway.
    always_comb begin
        rd_coef = '0;
        if (rd_ok) rd_coef = bank[rd_ch];
    end

endmodule

// File: rtl/mult.sv
// Pipelined multiplier: the product is registered PIPE_WIDTH times and
// every stage advances only while clken is high.
module mult #(
    parameter int A_W        = 16,
    parameter int B_W        = 16,
    parameter int PIPE_WIDTH = 4,
    parameter bit SIGNED     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clken,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] prod;
    logic [P_W-1:0] stage_q [PIPE_WIDTH];

    // Operands are extended to the full product width so the multiply is exact.
    if (SIGNED) begin : g_signed
        assign prod = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
    end else begin : g_unsigned
        assign prod = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
    end

    // Product shift register, frozen while clken is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_WIDTH; i++) stage_q[i] <= '0;
        end else if (clken) begin
            stage_q[0] <= prod;
            for (int i = 1; i < PIPE_WIDTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign p = stage_q[PIPE_WIDTH-1];

endmodule

// File: rtl/adc2v_mc.sv
// Multi-channel ADC-code to fixed-point voltage stage.
// v = ((raw*ADC_REF >> ADC_WIDTH) + bias[ch]) * gain[ch], low DATA_WIDTH bits.
// Optional feature macro: ADC2V_MC_SAT_EN (saturate instead of wrap, one
// extra output register stage).
// Handshake: a sample transfers when adc_valid_in & adc_ready_in; an output
// transfers when v_valid_out & v_ready_out; adc_ready_in = ~v_valid_out |
// v_ready_out and the whole pipeline advances only while adc_ready_in is high,
// so the output holds stable while stalled.
module adc2v_mc
    import cnn1d_pkg::*;
#(
    parameter int                    NUM_CH     = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FRACTION   = 24,
    parameter int                    PIPE_WIDTH = 4,
    parameter int unsigned           ADC_REF    = 2500,
    parameter logic [DATA_WIDTH-1:0] BIAS_INIT  = 32'hfffffb1e,
    parameter logic [DATA_WIDTH-1:0] GAIN_INIT  = 32'h000aaaab,
    localparam int                   CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_valid_in,
    output logic                  adc_ready_in,
    input  logic [CH_W-1:0]       adc_ch_in,
    input  logic [ADC_WIDTH-1:0]  adc_data_in,
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  err_bad_ch,
    output logic                  v_valid_out,
    input  logic                  v_ready_out,
    output logic [CH_W-1:0]       v_ch_out,
    output logic [DATA_WIDTH-1:0] v_data_out
);

    // Coefficients live in coef_t, so the datapath width is tied to COEF_W.
    if (DATA_WIDTH != COEF_W || FRACTION >= DATA_WIDTH) begin : g_param_check
        $error("adc2v_mc: DATA_WIDTH must equal COEF_W and exceed FRACTION");
    end

    localparam int REF_W = $clog2(ADC_REF + 1);
`ifdef ADC2V_MC_SAT_EN
    localparam int LAT = 2*PIPE_WIDTH + 2;
`else
    localparam int LAT = 2*PIPE_WIDTH + 1;
`endif
    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic                    ch_ok;
    logic                    in_vld;
    coef_t                   rd_coef;
    logic [LAT-1:0]          vld_q;
    logic [CH_W-1:0]         tag_q  [LAT];
    logic [DATA_WIDTH-1:0]   bias_q [PIPE_WIDTH];
    logic [DATA_WIDTH-1:0]   gain_q [PIPE_WIDTH+1];
    logic [ADC_WIDTH+REF_W-1:0] prod1;
    logic [ADC_WIDTH-1:0]    unused_scale_lsb;
    logic [DATA_WIDTH-1:0]   s1;
    logic [DATA_WIDTH-1:0]   u_q;
    logic [2*DATA_WIDTH-1:0] prod2;

    assign adc_ready_in = ~v_valid_out | v_ready_out;
    assign ch_ok        = ({1'b0, adc_ch_in} < NUM_CH_L);
    // Bad-tag samples are consumed but travel as bubbles.
    assign in_vld       = adc_valid_in & ch_ok;

    adc2v_coef_bank #(
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W),
        .BIAS_INIT (BIAS_INIT),
        .GAIN_INIT (GAIN_INIT)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .sel     (cfg_sel_e'(cfg_sel)),
        .wr_ch   (cfg_ch),
        .wr_data (cfg_data),
        .rd_ch   (adc_ch_in),
        .rd_coef (rd_coef)
    );

    // Sticky error on any consumed sample whose tag has no channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                            err_bad_ch <= 1'b0;
        else if (adc_valid_in && adc_ready_in && !ch_ok)     err_bad_ch <= 1'b1;
    end

    // Valid and tag travel alongside the data for the full latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (adc_ready_in) begin
            vld_q    <= {vld_q[LAT-2:0], in_vld};
            tag_q[0] <= adc_ch_in;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Coefficients are sampled at acceptance (old value on a same-cycle write)
    // and delayed to the stage that consumes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_WIDTH; i++)  bias_q[i] <= '0;
            for (int i = 0; i <= PIPE_WIDTH; i++) gain_q[i] <= '0;
        end else if (adc_ready_in) begin
            bias_q[0] <= rd_coef.bias;
            gain_q[0] <= rd_coef.gain;
            for (int i = 1; i < PIPE_WIDTH; i++)  bias_q[i] <= bias_q[i-1];
            for (int i = 1; i <= PIPE_WIDTH; i++) gain_q[i] <= gain_q[i-1];
        end
    end

    mult #(
        .A_W        (ADC_WIDTH),
        .B_W        (REF_W),
        .PIPE_WIDTH (PIPE_WIDTH),
        .SIGNED     (1'b0)
    ) u_mult_scale (
        .clk   (clk),
        .rst   (rst),
        .clken (adc_ready_in),
        .a     (adc_data_in),
        .b     (REF_W'(ADC_REF)),
        .p     (prod1)
    );

    // Dropping the ADC_WIDTH low bits is the divide by full-scale code.
    assign s1               = {{(DATA_WIDTH-REF_W){1'b0}}, prod1[ADC_WIDTH +: REF_W]};
    assign unused_scale_lsb = prod1[ADC_WIDTH-1:0];

    // Bias add, wrapping at DATA_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              u_q <= '0;
        else if (adc_ready_in) u_q <= s1 + bias_q[PIPE_WIDTH-1];
    end

    mult #(
        .A_W        (DATA_WIDTH),
        .B_W        (DATA_WIDTH),
        .PIPE_WIDTH (PIPE_WIDTH),
        .SIGNED     (1'b1)
    ) u_mult_gain (
        .clk   (clk),
        .rst   (rst),
        .clken (adc_ready_in),
        .a     (u_q),
        .b     (gain_q[PIPE_WIDTH]),
        .p     (prod2)
    );

`ifdef ADC2V_MC_SAT_EN
    logic                  ovf;
    logic [DATA_WIDTH-1:0] sat_q;

    // Overflow when the bits above the result's sign bit are not all copies of it.
    always_comb begin
        ovf = 1'b0;
        if (!((&prod2[2*DATA_WIDTH-1:DATA_WIDTH-1]) || !(|prod2[2*DATA_WIDTH-1:DATA_WIDTH-1])))
            ovf = 1'b1;
    end

    // Saturating output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= '0;
        end else if (adc_ready_in) begin
            if (ovf) sat_q <= prod2[2*DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            else     sat_q <= prod2[DATA_WIDTH-1:0];
        end
    end

    assign v_data_out = sat_q;
`else
    logic [DATA_WIDTH-1:0] unused_prod_hi;

    assign v_data_out     = prod2[DATA_WIDTH-1:0];
    assign unused_prod_hi = prod2[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

    assign v_valid_out = vld_q[LAT-1];
    assign v_ch_out    = tag_q[LAT-1];

endmodule
